alu_md_control_unit: RTL and testbench

- Successor to the combinational ALU control decoder, parametrised in datapath width and extended with an RV32M mode.
- Base RV32I ops: produces the 4-bit ALUSelection combinationally, with the existing ALUOp/func3/inst30 semantics.
- R-type ops with funct7[0]=1: runs an iterative multi-cycle MUL/DIV engine. Provides a busy/done handshake so the EX stage can stall the pipeline.

---
 rtl/alu_md_control_unit.sv | 194 +++++++++++++++++++
 tb/tb_alu_md_control_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_md_control_unit.sv
// rtl/alu_md_control_unit.sv - ALU select decoder with an iterative RV32M multiply/divide engine
//
// Purpose: decodes ALUOp/func3/inst30 into a 4-bit ALU select for base integer
// ops, and runs M-extension ops (R-type, funct7[0]=1) on a one-bit-per-cycle
// shift-add / restoring-divide engine with a busy/done handshake for stalling.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   ALUOp[1:0]          00 add, 01 sub, 10 func-decoded, 11 pass
//   func3[2:0]          instruction bits 14:12
//   inst30, inst25      instruction bits 30 and 25
//   isRType             opcode bit 5 (R-type vs I-type)
//   valid, flush        live instruction in EX / kill in-flight M op
//   rs1Data, rs2Data    operands
//   ALUSelection[3:0]   ALU select
//   mdSel               EX result comes from mdResult
//   mdResult            registered MUL/DIV result
//   mdBusy, mdDone      stall request / one-cycle result-valid pulse
//
// Build option: MD_ZERO_SKIP_EN - multiplies with a zero operand finish in one cycle.

module alu_md_control_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      func3,
  input  logic            inst30,
  input  logic            inst25,
  input  logic            isRType,
  input  logic            valid,
  input  logic            flush,
  input  logic [XLEN-1:0] rs1Data,
  input  logic [XLEN-1:0] rs2Data,
  output logic [3:0]      ALUSelection,
  output logic            mdSel,
  output logic [XLEN-1:0] mdResult,
  output logic            mdBusy,
  output logic            mdDone
);

  // Select encodings, kept identical to the ALU_* values in defines.v
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t state, state_nxt;

  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opb;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        f3;
  logic              neg_p;  // product / quotient sign
  logic              neg_a;  // remainder sign (dividend)

  logic is_m, m_start;
  assign is_m    = (ALUOp == 2'b10) & isRType & inst25;
  assign mdSel   = is_m;
  assign m_start = valid & is_m & (state == S_IDLE) & ~flush;
  assign mdBusy  = m_start | (state == S_MUL) | (state == S_DIV);
  assign mdDone  = (state == S_DONE) & ~flush;

  always_comb begin
    ALUSelection = ALU_ADD;
    case (ALUOp)
      2'b00: ALUSelection = ALU_ADD;
      2'b01: ALUSelection = ALU_SUB;
      2'b11: ALUSelection = ALU_PASS;
      default: begin
        case (func3)
          3'd0: ALUSelection = (inst30 & isRType) ? ALU_SUB : ALU_ADD;
          3'd1: ALUSelection = ALU_SLL;
          3'd2: ALUSelection = ALU_SLT;
          3'd3: ALUSelection = ALU_SLTU;
          3'd4: ALUSelection = ALU_XOR;
          3'd5: ALUSelection = inst30 ? ALU_SRA : ALU_SRL;
          3'd6: ALUSelection = ALU_OR;
          default: ALUSelection = ALU_AND;
        endcase
      end
    endcase
    if (is_m) ALUSelection = ALU_PASS;
  end

  // Operand signedness: rs1 unsigned only for MULHU/DIVU/REMU; rs2 also for MULHSU
  logic a_signed, b_signed, sa, sb;
  logic [XLEN-1:0] abs_a, abs_b;
  assign a_signed = ~(func3[0] & (func3[1] | func3[2]));
  assign b_signed = a_signed & (func3 != 3'd2);
  assign sa       = a_signed & rs1Data[XLEN-1];
  assign sb       = b_signed & rs2Data[XLEN-1];
  assign abs_a    = sa ? -rs1Data : rs1Data;
  assign abs_b    = sb ? -rs2Data : rs2Data;

  // One-cycle exits from IDLE and the result they produce
  logic div_zero, div_ovf, mul_skip, special;
  logic [XLEN-1:0] special_res;
  assign div_zero = func3[2] & (rs2Data == '0);
  assign div_ovf  = func3[2] & ~func3[0] & (rs1Data == INT_MIN) & (rs2Data == '1);
`ifdef MD_ZERO_SKIP_EN
  assign mul_skip = ~func3[2] & ((rs1Data == '0) | (rs2Data == '0));
`else
  assign mul_skip = 1'b0;
`endif
  assign special = div_zero | div_ovf | mul_skip;

  always_comb begin
    special_res = '0;
    if (div_zero)     special_res = func3[1] ? rs1Data : '1;
    else if (div_ovf) special_res = func3[1] ? '0 : rs1Data;
  end

  // Iteration datapath: acc = {hi, lo}; MUL adds into hi and shifts right,
  // DIV shifts {rem, dividend} left and keeps the trial subtract when it fits.
  logic [XLEN:0]     mul_sum, rem_sh, div_diff;
  logic [2*XLEN-1:0] step_nxt, prod;
  logic [XLEN-1:0]   quo, rem, mul_res, div_res, final_res;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff = rem_sh - {1'b0, opb};
    if (state == S_DIV)
      step_nxt = div_diff[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      step_nxt = {mul_sum, acc[XLEN-1:1]};
    prod      = neg_p ? -step_nxt : step_nxt;
    mul_res   = (f3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    quo       = step_nxt[XLEN-1:0];
    rem       = step_nxt[2*XLEN-1:XLEN];
    div_res   = f3[1] ? (neg_a ? -rem : rem) : (neg_p ? -quo : quo);
    final_res = (state == S_DIV) ? div_res : mul_res;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (m_start) begin
        if (special)       state_nxt = S_DONE;
        else if (func3[2]) state_nxt = S_DIV;
        else               state_nxt = S_MUL;
      end
      S_MUL, S_DIV: if (cnt == LAST_STEP) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      opb      <= '0;
      cnt      <= '0;
      f3       <= '0;
      neg_p    <= 1'b0;
      neg_a    <= 1'b0;
      mdResult <= '0;
    end else if (m_start) begin
      acc   <= {{XLEN{1'b0}}, abs_a};
      opb   <= abs_b;
      cnt   <= '0;
      f3    <= func3;
      neg_p <= sa ^ sb;
      neg_a <= sa;
      if (special) mdResult <= special_res;
    end else if ((state == S_MUL || state == S_DIV) && !flush) begin
      acc <= step_nxt;
      cnt <= cnt + CNT_W'(1);
      if (cnt == LAST_STEP) mdResult <= final_res;
    end
  end

endmodule

// File: tb/tb_alu_md_control_unit.sv
// tb/tb_alu_md_control_unit.sv - scoreboard bench for alu_md_control_unit

module tb_alu_md_control_unit;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_PASS = 4'd10;

`ifdef MD_ZERO_SKIP_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  logic        clk = 0;
  logic        rst;
  logic [1:0]  ALUOp;
  logic [2:0]  func3;
  logic        inst30, inst25, isRType, valid, flush;
  logic [31:0] rs1Data, rs2Data;
  logic [3:0]  ALUSelection;
  logic        mdSel, mdBusy, mdDone;
  logic [31:0] mdResult;

  alu_md_control_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .ALUOp(ALUOp), .func3(func3), .inst30(inst30),
    .inst25(inst25), .isRType(isRType), .valid(valid), .flush(flush),
    .rs1Data(rs1Data), .rs2Data(rs2Data), .ALUSelection(ALUSelection),
    .mdSel(mdSel), .mdResult(mdResult), .mdBusy(mdBusy), .mdDone(mdDone)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          at;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] last_exp = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
    end
  endtask

  // Monitor: every mdDone pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (mdDone) begin
      if (sb_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_done: got mdDone=1 at cycle %0d expected no pulse", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, "_result"}, mdResult, e.res);
        check({e.name, "_cycle"}, 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic set_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    ALUOp = 2'b10; isRType = 1; inst25 = 1; inst30 = 0;
    func3 = f3; rs1Data = a; rs2Data = b;
  endtask

  // Issues one M op (called #1 after a posedge) and returns once it completes
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input int lat, input string nm);
    int busy = 0;
    bit seen = 0;
    exp_t e;
    e.res = res; e.at = cyc + lat; e.name = nm;
    sb_q.push_back(e);
    last_exp = res;
    set_m(f3, a, b);
    valid = 1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (mdBusy) busy++;
      if (mdDone) seen = 1;
      @(posedge clk); #1;
      valid = 0;
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: got no mdDone expected one within 100 cycles", nm);
    end
    check({nm, "_busy_cycles"}, 32'(busy), 32'(lat));
  endtask

  initial begin
    rst = 1; valid = 0; flush = 0; ALUOp = 0; func3 = 0; inst30 = 0; inst25 = 0;
    isRType = 0; rs1Data = 0; rs2Data = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", mdResult, 32'h0);
    check("reset_done", {31'b0, mdDone}, 32'h0);
    check("reset_busy", {31'b0, mdBusy}, 32'h0);
    rst = 0;
    @(posedge clk); #1;

    // Base decode (combinational)
    ALUOp = 2'b10; func3 = 3'd5; inst30 = 1; isRType = 1; inst25 = 0; #1;
    check("dec_sra", {28'b0, ALUSelection}, {28'b0, ALU_SRA});
    check("dec_sra_mdsel", {31'b0, mdSel}, 32'h0);
    check("dec_sra_busy", {31'b0, mdBusy}, 32'h0);
    isRType = 0; func3 = 3'd0; #1;
    check("dec_addi", {28'b0, ALUSelection}, {28'b0, ALU_ADD});
    isRType = 1; #1;
    check("dec_sub", {28'b0, ALUSelection}, {28'b0, ALU_SUB});
    ALUOp = 2'b11; #1;
    check("dec_pass", {28'b0, ALUSelection}, {28'b0, ALU_PASS});
    ALUOp = 2'b01; #1;
    check("dec_op_sub", {28'b0, ALUSelection}, {28'b0, ALU_SUB});
    ALUOp = 2'b10; inst25 = 1; func3 = 3'd4; #1;
    check("dec_m_pass", {28'b0, ALUSelection}, {28'b0, ALU_PASS});
    check("dec_m_mdsel", {31'b0, mdSel}, 32'h1);
    @(posedge clk); #1;

    // Multiply / divide vectors
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 33, "mul");
    run_op(3'd3, 32'hFFFF_FFFD, 32'd7, 32'h0000_0006, 33, "mulhu");
    run_op(3'd1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 33, "mulh");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem");
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 33, "divu");
    run_op(3'd7, 32'd100, 32'd7, 32'd2, 33, "remu");
    run_op(3'd5, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1, "divu_zero");
    run_op(3'd7, 32'h1234, 32'd0, 32'h0000_1234, 1, "remu_zero");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, "rem_ovf");
    run_op(3'd0, 32'd0, 32'h55, 32'h0, ZLAT, "mul_zero");

    // Flush at iteration 10 of a DIVU: no pulse, result held
    set_m(3'd5, 32'd1000, 32'd3);
    valid = 1;
    @(posedge clk); #1;
    valid = 0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    @(negedge clk);
    check("flush_busy", {31'b0, mdBusy}, 32'h0);
    repeat (40) @(negedge clk);
    check("flush_result_held", mdResult, last_exp);

    // Asynchronous reset at iteration 20 of a MUL
    @(posedge clk); #1;
    set_m(3'd0, 32'hFFFF_FFFD, 32'd7);
    valid = 1;
    @(posedge clk); #1;
    valid = 0;
    repeat (19) @(posedge clk);
    #1;
    run_after_reset_check();
    repeat (40) @(negedge clk);

    // Engine still usable after the abort
    @(posedge clk); #1;
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 33, "divu_after_rst");

    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  task automatic run_after_reset_check();
    rst = 1;
    #1;
    check("async_rst_result", mdResult, 32'h0);
    check("async_rst_busy", {31'b0, mdBusy}, 32'h0);
    #1;
    rst = 0;
    last_exp = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1);
  end

endmodule
